ifq_fetch_sched: RTL and testbench
==================================

Name: ifq_fetch_sched

Overview:
- Fetch scheduler that sits in front of the instruction fetch queue.
- Generates cache-line read requests at the sequential fetch PC and tracks queue occupancy with a credit counter.
- Pushes returned instruction words into the queue, and on a taken branch flushes the queue and redirects fetch.
- Sits between the branch unit, the instruction cache read port and the IFQ FIFO; it replaces ad-hoc push/pc-increment sequencing.

Parameters:
- ADDR_W, 32, fetch address width in bits.
- DEPTH, 16, IFQ FIFO entries; must be at least WORDS.
- WORDS, 4, 32-bit instruction words per cache line; power of two.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- branch_valid  in  1  taken-branch redirect, single-cycle pulse
- branch_target  in  ADDR_W  redirect address, word aligned
- cache_req  out  1  line read request
- cache_addr  out  ADDR_W  line-aligned request address
- cache_gnt  in  1  request accepted this cycle
- dout_valid  in  1  cache data beat valid
- push_fifo  out  1  write current cache beat into IFQ
- pop_fifo  in  1  consumer removed one IFQ entry
- fifo_flush  out  1  clear IFQ, single-cycle pulse
- occupancy  out  $clog2(DEPTH)+1  IFQ entries held, per this block's count
- fifo_full  out  1  occupancy == DEPTH

Behaviour:
- Reset: state = IDLE; fetch_pc = RESET_PC; occupancy = 0; beat_idx = 0; skip = 0; every output = 0.
- fetch_pc is held line-aligned; skip is the word offset of the first valid word in the line.
- States:
  - IDLE: if DEPTH − occupancy ≥ WORDS, go to REQ next cycle.
  - REQ: cache_req = 1; cache_addr = fetch_pc, stable until grant. On cache_gnt, go to FILL with beat_idx = 0.
  - FILL: the cache returns exactly WORDS beats, which may be non-consecutive.
    - Each dout_valid increments beat_idx.
    - push_fifo = dout_valid && beat_idx ≥ skip (same cycle, combinational).
    - On the last beat: fetch_pc += WORDS*4; skip = 0.
    - Then go to REQ if space for WORDS more after this cycle's push/pop, else IDLE.
  - DRAIN: discards the remaining beats of a granted line; push_fifo = 0. After the last beat, go to REQ.
- Branch (branch_valid = 1), in any state, takes priority:
  - fifo_flush = 1 that same cycle.
  - occupancy = 0 next cycle; a pop or push in the same cycle is ignored.
  - fetch_pc = target with line bits cleared; skip = target[$clog2(WORDS)+1:2].
  - Next state by current state:
    - IDLE, or REQ without grant: REQ. cache_req drops for one cycle, then re-asserts with the new address.
    - REQ with cache_gnt the same cycle: DRAIN with beat_idx = 0.
    - FILL, beat not last: DRAIN; the beat is not pushed.
    - FILL, last beat: REQ.
- Occupancy: +1 on push, −1 on pop, unchanged when both occur.
  - pop with occupancy 0 is ignored.
  - push never occurs at DEPTH, because a request is only issued with ≥ WORDS free.
- Back-to-back branches: each branch restarts the redirect; the DRAIN beat count continues.
- Latency: branch to new cache_req is 2 cycles when no line is outstanding. The first pushed word is the word at branch_target.
- Reset asserted mid-operation: immediate return to reset values; outstanding cache beats are the cache's responsibility.

Optional Feature:
- Macro: IFQ_PERF_CNT_EN.
- Defined: adds outputs line_cnt[31:0] and flush_cnt[31:0].
  - line_cnt increments on each completed FILL.
  - flush_cnt increments on each branch_valid.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC = 0x100, no pops → requests at 0x100, 0x110, 0x120, 0x130; 16 pushes; fifo_full = 1; cache_req stays 0.
- Full queue, then pop 4 → occupancy 12; cache_req asserts with addr 0x140 within 2 cycles.
- Branch in IDLE to 0x208 → fifo_flush pulse; occupancy 0; request at 0x200; only beats 2 and 3 pushed (2 pushes); next request at 0x210.
- Branch during FILL after beat 1 to 0x300 → beats 1–3 of the old line are not pushed; the next cache_req to 0x300 is issued only after the old line's 4th beat.
- Simultaneous push and pop at occupancy 5 → stays 5; pop at occupancy 0 → stays 0; pop together with branch → 0.
- With IFQ_PERF_CNT_EN: 3 lines completed and 2 branches → line_cnt = 3, flush_cnt = 2.

Source files
------------

// File: rtl/ifq_fetch_sched.sv
// rtl/ifq_fetch_sched.sv - IFQ fetch scheduler: line requests, beat pushes, credit count, branch redirect; optional IFQ_PERF_CNT_EN counters
module ifq_fetch_sched #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 16,
    parameter int                WORDS    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_branch_valid,
    input  logic [ADDR_W-1:0]        i_branch_target,
    output logic                     o_cache_req,
    output logic [ADDR_W-1:0]        o_cache_addr,
    input  logic                     i_cache_gnt,
    input  logic                     i_dout_valid,
    output logic                     o_push_fifo,
    input  logic                     i_pop_fifo,
    output logic                     o_fifo_flush,
    output logic [$clog2(DEPTH):0]   o_occupancy,
    output logic                     o_fifo_full
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]              o_line_cnt,
    output logic [31:0]              o_flush_cnt
`endif
);

    localparam int LW     = $clog2(WORDS);
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int LINE_B = LW + 2;
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WORDS * 4);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~(LINE_BYTES - ADDR_W'(1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FILL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [LW-1:0]     r_skip, w_skip_nxt;
    logic [LW-1:0]     r_beat_idx, w_beat_idx_nxt;
    logic [OCC_W-1:0]  r_occ, w_occ_nxt;
    logic [OCC_W-1:0]  w_free_now, w_free_nxt;
    logic              r_redirect;
    logic              w_beat_last, w_pop_ok, w_push, w_space_nxt;

    // r_redirect holds cache_req low for the cycle after a branch so the new address is seen cleanly
    assign o_cache_req  = (r_state == S_REQ) && !r_redirect;
    assign o_cache_addr = o_cache_req ? r_fetch_pc : '0;
    assign o_fifo_flush = i_branch_valid;
    assign o_occupancy  = r_occ;
    assign o_fifo_full  = (r_occ == OCC_W'(DEPTH));

    assign w_beat_last = i_dout_valid && (r_beat_idx == LW'(WORDS - 1));
    assign w_pop_ok    = i_pop_fifo && (r_occ != '0);
    // Words ahead of the branch target in the first line are dropped; a redirecting beat is never pushed
    assign w_push      = (r_state == S_FILL) && i_dout_valid && (r_beat_idx >= r_skip) && !i_branch_valid;
    assign o_push_fifo = w_push;

    assign w_free_now  = OCC_W'(DEPTH) - r_occ;
    assign w_free_nxt  = OCC_W'(DEPTH) - w_occ_nxt;
    assign w_space_nxt = (w_free_nxt >= OCC_W'(WORDS));

    // Credit counter update: a branch empties the queue and overrides any same-cycle push/pop
    always_comb begin
        w_occ_nxt = r_occ;
        if (i_branch_valid) begin
            w_occ_nxt = '0;
        end else if (w_push && !w_pop_ok) begin
            w_occ_nxt = r_occ + OCC_W'(1);
        end else if (!w_push && w_pop_ok) begin
            w_occ_nxt = r_occ - OCC_W'(1);
        end
    end

    // Next-state logic: sequential fetch first, then branch redirect overrides
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_skip_nxt     = r_skip;
        w_beat_idx_nxt = r_beat_idx;

        case (r_state)
            S_IDLE: begin
                if (w_free_now >= OCC_W'(WORDS)) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (o_cache_req && i_cache_gnt) begin
                    w_state_nxt    = S_FILL;
                    w_beat_idx_nxt = '0;
                end
            end
            S_FILL: begin
                if (i_dout_valid) begin
                    w_beat_idx_nxt = r_beat_idx + LW'(1);
                    if (w_beat_last) begin
                        w_fetch_pc_nxt = r_fetch_pc + LINE_BYTES;
                        w_skip_nxt     = '0;
                        w_state_nxt    = w_space_nxt ? S_REQ : S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (i_dout_valid) begin
                    w_beat_idx_nxt = r_beat_idx + LW'(1);
                    if (w_beat_last) begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (i_branch_valid) begin
            w_fetch_pc_nxt = i_branch_target & LINE_MASK;
            w_skip_nxt     = i_branch_target[LINE_B-1:2];
            case (r_state)
                S_REQ: begin
                    if (o_cache_req && i_cache_gnt) begin
                        w_state_nxt    = S_DRAIN;
                        w_beat_idx_nxt = '0;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_FILL, S_DRAIN: w_state_nxt = w_beat_last ? S_REQ : S_DRAIN;
                default:         w_state_nxt = S_REQ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_skip     <= '0;
            r_beat_idx <= '0;
            r_occ      <= '0;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_skip     <= w_skip_nxt;
            r_beat_idx <= w_beat_idx_nxt;
            r_occ      <= w_occ_nxt;
            r_redirect <= i_branch_valid;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] r_line_cnt, r_flush_cnt;
    logic        w_line_done;

    assign w_line_done = (r_state == S_FILL) && w_beat_last;
    assign o_line_cnt  = r_line_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_line_done) begin
                r_line_cnt <= r_line_cnt + 32'd1;
            end
            if (i_branch_valid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifq_fetch_sched.sv
// tb/tb_ifq_fetch_sched.sv - scoreboard bench for ifq_fetch_sched with a simple cache responder
module tb_ifq_fetch_sched;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 16;
    localparam int          WORDS    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_branch_valid = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        o_cache_req;
    logic [31:0] o_cache_addr;
    logic        i_cache_gnt = 1'b0;
    logic        i_dout_valid = 1'b0;
    logic        o_push_fifo;
    logic        i_pop_fifo = 1'b0;
    logic        o_fifo_flush;
    logic [4:0]  o_occupancy;
    logic        o_fifo_full;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] o_line_cnt;
    logic [31:0] o_flush_cnt;
`endif

    always #5 clk = ~clk;

    ifq_fetch_sched #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORDS(WORDS), .RESET_PC(RESET_PC)
    ) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .i_branch_valid(i_branch_valid),
        .i_branch_target(i_branch_target),
        .o_cache_req(o_cache_req),
        .o_cache_addr(o_cache_addr),
        .i_cache_gnt(i_cache_gnt),
        .i_dout_valid(i_dout_valid),
        .o_push_fifo(o_push_fifo),
        .i_pop_fifo(i_pop_fifo),
        .o_fifo_flush(o_fifo_flush),
        .o_occupancy(o_occupancy),
        .o_fifo_full(o_fifo_full)
`ifdef IFQ_PERF_CNT_EN
        ,
        .o_line_cnt(o_line_cnt),
        .o_flush_cnt(o_flush_cnt)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] grant_log[$];
    int          pend_skip = 0;
    logic [4:0]  grant_occ = '0;

    int          m_beats_left = 0;
    int          m_beat = 0;
    logic [31:0] m_line_addr = '0;
    bit          m_stall = 1'b0;
    bit          gap_mode = 1'b0;
    bit          gap_phase = 1'b0;
    bit          gnt_en = 1'b1;
    int          gnt_limit = 1000000;

    bit          s_push, s_req;
    logic [31:0] s_addr;

    function automatic bit beat_next();
        return (m_beats_left > 0) && !m_stall && !(gap_mode && gap_phase);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        grant_log.delete();
        pend_skip    = 0;
        m_beats_left = 0;
        m_beat       = 0;
        m_stall      = 1'b0;
    endtask

    task automatic tick(input bit br, input logic [31:0] tgt, input bit pop);
        bit          gnt, dv;
        logic [31:0] got, exp_w, addr;
        @(negedge clk);
        dv  = beat_next();
        gnt = o_cache_req && gnt_en && (grant_log.size() < gnt_limit);
        i_cache_gnt     = gnt;
        i_dout_valid    = dv;
        i_branch_valid  = br;
        i_branch_target = tgt;
        i_pop_fifo      = pop;
        #1;
        s_push = o_push_fifo;
        s_req  = o_cache_req;
        s_addr = o_cache_addr;
        addr   = o_cache_addr;
        if (o_push_fifo) begin
            n_checks++;
            got = m_line_addr + 32'(m_beat * 4);
            if (br) begin
                n_fail++;
                $display("FAIL push_on_branch: pushed word %h, required no push", got);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_push: pushed word %h, required no push", got);
            end else begin
                exp_w = exp_q.pop_front();
                if (got !== exp_w) begin
                    n_fail++;
                    $display("FAIL push_word: pushed %h, required %h", got, exp_w);
                end
            end
        end
        if (o_fifo_flush !== br) begin
            n_checks++;
            n_fail++;
            $display("FAIL fifo_flush: got %b, required %b", o_fifo_flush, br);
        end else if (br) begin
            n_checks++;
        end
        if (br) begin
            exp_q.delete();
            pend_skip = int'(tgt[3:2]);
        end
        if (gnt) begin
            grant_log.push_back(addr);
            grant_occ = o_occupancy;
            if (!br) begin
                for (int b = pend_skip; b < WORDS; b++) exp_q.push_back(addr + 32'(b * 4));
                pend_skip = 0;
            end
        end
        @(posedge clk);
        if (dv) begin
            m_beat++;
            m_beats_left--;
        end
        if (gnt) begin
            m_line_addr  = addr;
            m_beat       = 0;
            m_beats_left = WORDS;
        end
        gap_phase = !gap_phase;
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_clear();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (o_occupancy !== 5'd0 || o_cache_req !== 1'b0 || o_fifo_full !== 1'b0 ||
            o_push_fifo !== 1'b0 || o_fifo_flush !== 1'b0 || o_cache_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: occ=%0d req=%b full=%b push=%b flush=%b addr=%h, required all 0",
                     o_occupancy, o_cache_req, o_fifo_full, o_push_fifo, o_fifo_flush, o_cache_addr);
        end
        i_rst_n = 1'b1;
        tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: cache_req=%b, required 0", s_req);
        end
    endtask

    task automatic test_fill_to_full();
        bit req_seen = 1'b0;
        gap_mode = 1'b1;
        for (int i = 0; i < 200 && !o_fifo_full; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (o_fifo_full !== 1'b1 || o_occupancy !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_full: full=%b occ=%0d, required full=1 occ=16", o_fifo_full, o_occupancy);
        end
        n_checks++;
        if (grant_log.size() != 4) begin
            n_fail++;
            $display("FAIL fill_req_count: got %0d requests, required 4", grant_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (grant_log[k] !== RESET_PC + 32'(k * 16)) begin
                    n_fail++;
                    $display("FAIL fill_req_addr%0d: got %h, required %h", k, grant_log[k], RESET_PC + 32'(k * 16));
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill_pushes: %0d words never pushed, required 0", exp_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            req_seen |= s_req;
        end
        n_checks++;
        if (req_seen) begin
            n_fail++;
            $display("FAIL full_no_req: cache_req=1 while full, required 0");
        end
    endtask

    task automatic test_pop_refill();
        int  n0 = grant_log.size();
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (o_occupancy !== 5'd12) begin
            n_fail++;
            $display("FAIL pop4_occ: got %0d, required 12", o_occupancy);
        end
        for (int i = 0; i < 2 && grant_log.size() == n0; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (grant_log.size() == n0) begin
            n_fail++;
            $display("FAIL refill_req: no request within 2 cycles, required request at 00000140");
        end else if (grant_log[n0] !== 32'h140) begin
            n_fail++;
            $display("FAIL refill_req: got %h, required 00000140", grant_log[n0]);
        end
        for (int i = 0; i < 40 && !o_fifo_full; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (o_fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_full: full=%b occ=%0d, required full=1", o_fifo_full, o_occupancy);
        end
    endtask

    task automatic test_branch_idle();
        int n0;
        tick(1'b1, 32'h208, 1'b0);
        n_checks++;
        if (o_occupancy !== 5'd0 || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_idle_flush: occ=%0d req=%b, required occ=0 req=0", o_occupancy, s_req);
        end
        n0 = grant_log.size();
        tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_gap: cache_req=%b one cycle after branch, required 0", s_req);
        end
        tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL branch_latency: req=%b addr=%h two cycles after branch, required 1 / 00000200", s_req, s_addr);
        end
        for (int i = 0; i < 40 && grant_log.size() < n0 + 2; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (grant_log.size() < n0 + 2) begin
            n_fail++;
            $display("FAIL branch_next_req: %0d requests after branch, required 2", grant_log.size() - n0);
        end else begin
            if (grant_log[n0 + 1] !== 32'h210) begin
                n_fail++;
                $display("FAIL branch_next_req: got %h, required 00000210", grant_log[n0 + 1]);
            end
            n_checks++;
            if (grant_occ !== 5'd2) begin
                n_fail++;
                $display("FAIL branch_skip_pushes: occ=%0d after first line, required 2", grant_occ);
            end
        end
    endtask

    task automatic test_branch_fill();
        int n0;
        bit req_early = 1'b0;
        gap_mode = 1'b0;
        n0 = grant_log.size();
        tick(1'b1, 32'h280, 1'b0);
        for (int i = 0; i < 20 && grant_log.size() == n0; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (grant_log.size() == n0 || grant_log[grant_log.size() - 1] !== 32'h280) begin
            n_fail++;
            $display("FAIL redirect_280: last request %h, required 00000280",
                     grant_log.size() == n0 ? 32'h0 : grant_log[grant_log.size() - 1]);
        end
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h300, 1'b0);
        n_checks++;
        if (m_beat != 2 || s_push !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_mid_fill: beat count %0d push=%b, required 2 / 0", m_beat, s_push);
        end
        n0 = grant_log.size();
        m_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            req_early |= s_req;
        end
        m_stall = 1'b0;
        for (int i = 0; i < 10 && m_beats_left > 0; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            req_early |= s_req;
        end
        n_checks++;
        if (req_early || m_beats_left != 0) begin
            n_fail++;
            $display("FAIL drain_req: req_before_last_beat=%b beats_left=%0d, required 0 / 0", req_early, m_beats_left);
        end
        for (int i = 0; i < 5 && grant_log.size() == n0; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (grant_log.size() == n0 || grant_log[n0] !== 32'h300) begin
            n_fail++;
            $display("FAIL drain_next_req: got %h, required 00000300",
                     grant_log.size() == n0 ? 32'h0 : grant_log[n0]);
        end
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0 || o_occupancy !== 5'd4) begin
            n_fail++;
            $display("FAIL line_300_pushes: occ=%0d pending=%0d, required 4 / 0", o_occupancy, exp_q.size());
        end
    endtask

    task automatic test_push_pop();
        int n0;
        gap_mode = 1'b1;
        for (int i = 0; i < 40 && !(o_occupancy == 5'd5 && beat_next()); i++) tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (s_push !== 1'b1 || o_occupancy !== 5'd5) begin
            n_fail++;
            $display("FAIL push_pop: push=%b occ=%0d, required 1 / 5", s_push, o_occupancy);
        end
        n0 = grant_log.size();
        tick(1'b1, 32'h400, 1'b1);
        n_checks++;
        if (o_occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL pop_with_branch: occ=%0d, required 0", o_occupancy);
        end
        tick(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (o_occupancy !== 5'd0) begin
            n_fail++;
            $display("FAIL pop_at_empty: occ=%0d, required 0", o_occupancy);
        end
        for (int i = 0; i < 60 && !(grant_log.size() > n0 && exp_q.size() == 0); i++) tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (grant_log.size() == n0 || grant_log[n0] !== 32'h400 || o_occupancy !== 5'd4) begin
            n_fail++;
            $display("FAIL redirect_400: req=%h occ=%0d, required 00000400 / 4",
                     grant_log.size() == n0 ? 32'h0 : grant_log[n0], o_occupancy);
        end
    endtask

    task automatic test_midreset_perf();
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0);
        #3;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_occupancy !== 5'd0 || o_cache_req !== 1'b0 || o_fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: occ=%0d req=%b full=%b, required 0", o_occupancy, o_cache_req, o_fifo_full);
        end
`ifdef IFQ_PERF_CNT_EN
        n_checks++;
        if (o_line_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: line_cnt=%0d flush_cnt=%0d, required 0 / 0", o_line_cnt, o_flush_cnt);
        end
`endif
        model_clear();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        i_rst_n = 1'b1;
        gnt_en = 1'b0;
        tick(1'b1, 32'h500, 1'b0);
        tick(1'b1, 32'h600, 1'b0);
        gnt_en    = 1'b1;
        gnt_limit = 3;
        for (int i = 0; i < 200 && !(grant_log.size() == 3 && exp_q.size() == 0 && m_beats_left == 0); i++)
            tick(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (grant_log.size() != 3 || grant_log[0] !== 32'h600 || o_occupancy !== 5'd12) begin
            n_fail++;
            $display("FAIL back_to_back_branch: lines=%0d first=%h occ=%0d, required 3 / 00000600 / 12",
                     grant_log.size(), grant_log.size() == 0 ? 32'h0 : grant_log[0], o_occupancy);
        end
`ifdef IFQ_PERF_CNT_EN
        n_checks++;
        if (o_line_cnt !== 32'd3 || o_flush_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counts: line_cnt=%0d flush_cnt=%0d, required 3 / 2", o_line_cnt, o_flush_cnt);
        end
`endif
        gnt_limit = 1000000;
    endtask

    initial begin
        test_reset();
        test_fill_to_full();
        test_pop_refill();
        test_branch_idle();
        test_branch_fill();
        test_push_pop();
        test_midreset_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
